// File: rtl/psum_accumulator.sv
// psum_accumulator
// Accumulates a runtime-programmable number of consecutive signed partial sums
// (K-dimension tiles) from the dot-product adder tree into one saturating
// signed result, presented through a valid/ready output register.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   clear            synchronous flush of the partial group and any pending result
//   num_tiles        psums per group, sampled on the group's first beat (0 acts as 1)
//   in_valid/ready   psum beat handshake; in_ready is combinational from out_ready
//   in_psum          signed partial sum
//   out_valid/ready  result handshake
//   out_acc          signed accumulated result
//   out_sat          sticky saturation flag for the group
//   busy             group in progress or result pending
//
// ACC_W must be >= PSUM_W.
module psum_accumulator #(
    parameter int unsigned PSUM_W = 22,
    parameter int unsigned ACC_W  = 32,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic [CNT_W-1:0]  num_tiles,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PSUM_W-1:0] in_psum,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic              out_sat,
    output logic              busy
);

    localparam int unsigned SUM_W = ACC_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   n_lat_q, n_lat_d;
    logic               sat_q, sat_d;

    logic               accept;
    logic               start;
    logic [SUM_W-1:0]   psum_ext;
    logic [SUM_W-1:0]   sum;
    logic               ovf;
    logic [ACC_W-1:0]   sum_clamped;
    logic [CNT_W-1:0]   n_sel;
    logic [CNT_W-1:0]   cnt_inc;

    // Beat acceptance; clear blocks any beat in its cycle
    assign in_ready = !clear && ((state_q != S_HOLD) || out_ready);
    assign accept   = in_valid && in_ready;

    // Saturating add: one guard bit detects overflow of the ACC_W result
    assign psum_ext    = SUM_W'($signed(in_psum));
    assign sum         = {acc_q[ACC_W-1], acc_q} + psum_ext;
    assign ovf         = sum[ACC_W] != sum[ACC_W-1];
    assign sum_clamped = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                    : {1'b0, {(ACC_W-1){1'b1}}};

    assign n_sel   = (num_tiles == '0) ? CNT_W'(1) : num_tiles;
    assign cnt_inc = cnt_q + CNT_W'(1);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            n_lat_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            n_lat_q <= n_lat_d;
            sat_q   <= sat_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        n_lat_d = n_lat_q;
        sat_d   = sat_q;
        start   = 1'b0;

        case (state_q)
            S_IDLE: begin
                start = accept;
            end
            S_ACCUM: begin
                if (accept) begin
                    acc_d = ovf ? sum_clamped : sum[ACC_W-1:0];
                    sat_d = sat_q | ovf;
                    cnt_d = cnt_inc;
                    if (cnt_inc == n_lat_q) begin
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                // A beat accepted alongside the result handshake opens the next group
                if (out_ready) begin
                    start   = accept;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // First beat of a group: latch length, load accumulator, drop old sat
        if (start) begin
            n_lat_d = n_sel;
            acc_d   = psum_ext[ACC_W-1:0];
            cnt_d   = CNT_W'(1);
            sat_d   = 1'b0;
            state_d = (n_sel == CNT_W'(1)) ? S_HOLD : S_ACCUM;
        end

        if (clear) begin
            state_d = S_IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            sat_d   = 1'b0;
        end
    end

    assign out_valid = (state_q == S_HOLD);
    assign out_acc   = acc_q;
    assign out_sat   = sat_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_psum_accumulator.sv
// Self-checking bench for psum_accumulator: directed scenarios from the test
// plan plus randomized traffic against a transaction-level reference model.
module tb_psum_accumulator;

    localparam int unsigned PSUM_W = 22;
    localparam int unsigned ACC_W  = 24;
    localparam int unsigned CNT_W  = 8;
    localparam longint MAXV = (longint'(1) <<< (ACC_W - 1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (ACC_W - 1));

    logic              clk;
    logic              rst_n;
    logic              clear;
    logic [CNT_W-1:0]  num_tiles;
    logic              in_valid;
    logic              in_ready;
    logic [PSUM_W-1:0] in_psum;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_acc;
    logic              out_sat;
    logic              busy;

    int checks;
    int failures;

    // Reference model state (group-level view)
    bit     m_pending;
    bit     m_in_group;
    int     m_cnt;
    int     m_n;
    longint m_acc;
    bit     m_sat;
    longint m_res_acc;
    bit     m_res_sat;

    psum_accumulator #(
        .PSUM_W(PSUM_W),
        .ACC_W (ACC_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .num_tiles(num_tiles),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_psum  (in_psum),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_acc  (out_acc),
        .out_sat  (out_sat),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_pending  = 1'b0;
        m_in_group = 1'b0;
        m_cnt      = 0;
        m_n        = 0;
        m_acc      = 0;
        m_sat      = 1'b0;
    endtask

    // Advance one clock and update the model from the inputs presented
    task automatic tick();
        bit     acc_b;
        bit     hs;
        longint p;
        acc_b = in_valid && !clear && (!m_pending || out_ready);
        hs    = m_pending && out_ready && !clear;
        p     = longint'($signed(in_psum));
        @(posedge clk);
        if (clear) begin
            model_reset();
        end else begin
            if (hs) m_pending = 1'b0;
            if (acc_b) begin
                if (!m_in_group) begin
                    m_n   = (num_tiles == 0) ? 1 : int'(num_tiles);
                    m_acc = p;
                    m_sat = 1'b0;
                    m_cnt = 1;
                end else begin
                    m_acc = m_acc + p;
                    if (m_acc > MAXV) begin
                        m_acc = MAXV;
                        m_sat = 1'b1;
                    end else if (m_acc < MINV) begin
                        m_acc = MINV;
                        m_sat = 1'b1;
                    end
                    m_cnt++;
                end
                if (m_cnt == m_n) begin
                    m_pending  = 1'b1;
                    m_res_acc  = m_acc;
                    m_res_sat  = m_sat;
                    m_in_group = 1'b0;
                end else begin
                    m_in_group = 1'b1;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ctrl: out_valid=%b busy=%b in_ready=%b, want 0 0 1",
                     out_valid, busy, in_ready);
        end
        checks++;
        if (out_acc !== '0 || out_sat !== 1'b0) begin
            failures++;
            $display("FAIL reset_data: out_acc=%0h out_sat=%b, want 0 0", out_acc, out_sat);
        end
    endtask

    task automatic test_basic();
        int vals[4];
        vals = '{100, -30, 7, 1000};
        num_tiles = 8'd4;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_psum  = PSUM_W'(vals[i]);
            tick();
            if (i == 2) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL basic_early: out_valid=%b after 3 beats, want 0", out_valid);
                end
            end
        end
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_acc !== ACC_W'(1077) || out_sat !== 1'b0) begin
            failures++;
            $display("FAIL basic_result: valid=%b acc=%0d sat=%b, want 1 1077 0",
                     out_valid, $signed(out_acc), out_sat);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_idle: out_valid=%b busy=%b, want 0 0", out_valid, busy);
        end
    endtask

    task automatic test_back_to_back();
        int vals[3];
        vals = '{5, 6, 7};
        num_tiles = 8'd1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_psum  = PSUM_W'(vals[i]);
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_ready[%0d]: in_ready=%b, want 1", i, in_ready);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_acc !== ACC_W'(vals[i])) begin
                failures++;
                $display("FAIL b2b_result[%0d]: valid=%b acc=%0d, want 1 %0d",
                         i, out_valid, $signed(out_acc), vals[i]);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        num_tiles = 8'd2;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_psum   = PSUM_W'(3);
        tick();
        in_psum   = PSUM_W'(4);
        tick();
        in_psum   = PSUM_W'(99);
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_acc !== ACC_W'(7)) begin
                failures++;
                $display("FAIL bp_hold[%0d]: in_ready=%b valid=%b acc=%0d, want 0 1 7",
                         i, in_ready, out_valid, $signed(out_acc));
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_ready: in_ready=%b, want 1", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL bp_release: valid=%b busy=%b, want 0 0 (stalled beat not consumed)",
                     out_valid, busy);
        end
    endtask

    task automatic test_saturation();
        out_ready = 1'b1;
        num_tiles = 8'd8;
        in_valid  = 1'b1;
        in_psum   = PSUM_W'(2097151);
        for (int i = 0; i < 8; i++) tick();
        checks++;
        if (out_valid !== 1'b1 || out_acc !== ACC_W'(8388607) || out_sat !== 1'b1) begin
            failures++;
            $display("FAIL sat_pos: valid=%b acc=%0d sat=%b, want 1 8388607 1",
                     out_valid, $signed(out_acc), out_sat);
        end
        in_psum = PSUM_W'(-2097152);
        for (int i = 0; i < 8; i++) tick();
        checks++;
        if (out_valid !== 1'b1 || out_acc !== ACC_W'(-8388608) || out_sat !== 1'b1) begin
            failures++;
            $display("FAIL sat_neg: valid=%b acc=%0d sat=%b, want 1 -8388608 1",
                     out_valid, $signed(out_acc), out_sat);
        end
        num_tiles = 8'd2;
        in_psum   = PSUM_W'(1);
        tick();
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_acc !== ACC_W'(2) || out_sat !== 1'b0) begin
            failures++;
            $display("FAIL sat_recover: valid=%b acc=%0d sat=%b, want 1 2 0",
                     out_valid, $signed(out_acc), out_sat);
        end
        tick();
    endtask

    task automatic test_num_tiles();
        out_ready = 1'b1;
        num_tiles = 8'd0;
        in_valid  = 1'b1;
        in_psum   = PSUM_W'(42);
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_acc !== ACC_W'(42)) begin
            failures++;
            $display("FAIL ntiles_zero: valid=%b acc=%0d, want 1 42", out_valid, $signed(out_acc));
        end
        num_tiles = 8'd3;
        in_psum   = PSUM_W'(1);
        tick();
        num_tiles = 8'd5;
        in_psum   = PSUM_W'(2);
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL ntiles_mid: out_valid=%b after 2 of 3 beats, want 0", out_valid);
        end
        in_psum = PSUM_W'(3);
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_acc !== ACC_W'(6)) begin
            failures++;
            $display("FAIL ntiles_latched: valid=%b acc=%0d, want 1 6", out_valid, $signed(out_acc));
        end
        tick();
    endtask

    task automatic test_clear_reset();
        out_ready = 1'b1;
        num_tiles = 8'd4;
        in_valid  = 1'b1;
        in_psum   = PSUM_W'(10);
        tick();
        in_psum   = PSUM_W'(11);
        tick();
        clear   = 1'b1;
        in_psum = PSUM_W'(500);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL clear_ready: in_ready=%b during clear, want 0", in_ready);
        end
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL clear_flush: valid=%b busy=%b, want 0 0", out_valid, busy);
        end
        num_tiles = 8'd1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_psum   = PSUM_W'(77);
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL rst_prehold: out_valid=%b, want 1", out_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_acc !== '0 || busy !== 1'b0 || out_sat !== 1'b0) begin
            failures++;
            $display("FAIL rst_async: valid=%b acc=%0d busy=%b sat=%b, want 0 0 0 0",
                     out_valid, $signed(out_acc), busy, out_sat);
        end
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        num_tiles = 8'd2;
        in_valid  = 1'b1;
        in_psum   = PSUM_W'(10);
        tick();
        in_psum   = PSUM_W'(20);
        tick();
        in_valid  = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_acc !== ACC_W'(30)) begin
            failures++;
            $display("FAIL rst_fresh: valid=%b acc=%0d, want 1 30", out_valid, $signed(out_acc));
        end
        tick();
    endtask

    task automatic test_random();
        int errs;
        logic [ACC_W-1:0] exp_acc;
        errs = 0;
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom % 4) != 0;
            in_psum   = PSUM_W'($urandom);
            num_tiles = CNT_W'($urandom % 7);
            out_ready = ($urandom % 3) != 0;
            clear     = ($urandom % 64) == 0;
            #1;
            checks++;
            if (in_ready !== (!clear && (!m_pending || out_ready))) begin
                failures++;
                errs++;
                if (errs < 10) $display("FAIL rnd_ready[%0d]: in_ready=%b, want %b", i, in_ready,
                                        !clear && (!m_pending || out_ready));
            end
            tick();
            checks++;
            if (out_valid !== m_pending || busy !== (m_pending || m_in_group)) begin
                failures++;
                errs++;
                if (errs < 10) $display("FAIL rnd_ctrl[%0d]: valid=%b busy=%b, want %b %b", i,
                                        out_valid, busy, m_pending, m_pending || m_in_group);
            end
            if (m_pending) begin
                exp_acc = ACC_W'(m_res_acc);
                checks++;
                if (out_acc !== exp_acc || out_sat !== m_res_sat) begin
                    failures++;
                    errs++;
                    if (errs < 10) $display("FAIL rnd_result[%0d]: acc=%0d sat=%b, want %0d %b", i,
                                            $signed(out_acc), out_sat, m_res_acc, m_res_sat);
                end
            end
        end
        clear    = 1'b0;
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        clear     = 1'b0;
        num_tiles = '0;
        in_valid  = 1'b0;
        in_psum   = '0;
        out_ready = 1'b0;
        model_reset();
        #23;
        test_reset();
        rst_n = 1'b1;
        #1;
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_saturation();
        test_num_tiles();
        test_clear_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
